demux_1x4_nbit_stream: RTL and testbench
========================================

DEMUX_1X4_NBIT_STREAM -- requirements
Module: demux_1x4_nbit_stream

Interface
REQ-001 Parameter: n, default 4, data width of the input word and of each output word.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 w  input  n  input data word.
REQ-005 sel  input  2  destination select: 0 to f0, 1 to f1, 2 to f2, 3 to f3.
REQ-006 in_valid  input  1  w/sel valid this cycle.
REQ-007 in_ready  output  1  block accepts w/sel this cycle.
REQ-008 f0, f1, f2, f3  output  n each  registered output words.
REQ-009 out_valid  output  4  bit k set means fk holds an undelivered word.
REQ-010 out_ready  input  4  bit k set means the consumer of fk takes the word this cycle.
REQ-011 cnt  output  32  four 8-bit delivery counters, cnt[8k+7:8k] for output k; present only per REQ-027.

Function
REQ-012 Input transfer occurs when in_valid && in_ready on a rising edge; output-k transfer occurs when out_valid[k] && out_ready[k].
REQ-013 in_ready shall be combinational: !out_valid[sel] || out_ready[sel]; no dependence on in_valid.
REQ-014 On an input transfer, w shall be loaded into f[sel] and out_valid[sel] set on that edge; latency is 1 cycle from accept to out_valid.
REQ-015 Each output slot holds exactly one word; a full slot whose consumer is not ready shall block only inputs addressed to it (in_ready low when sel points to it).
REQ-016 Simultaneous output-k transfer and input transfer to k in the same cycle: new word loaded, out_valid[k] stays 1, no bubble.
REQ-017 Output-k transfer with no input to k: out_valid[k] clears on that edge.
REQ-018 fk shall hold its last value while out_valid[k] is 0 and while stalled; unselected outputs never change.
REQ-019 out_ready[k] asserted while out_valid[k] is 0 has no effect.
REQ-020 sel and w are sampled only on an input transfer; changes while in_valid is 0 or in_ready is 0 have no effect.
REQ-021 All four outputs operate independently; delivery order is preserved per output, not across outputs.

Reset
REQ-022 While reset_n is 0 at a rising edge: f0..f3 = 0, out_valid = 4'b0000, cnt = 0.
REQ-023 During reset in_ready shall still follow REQ-013 but no transfer is recorded; after reset in_ready = 1 for every sel.
REQ-024 Reset asserted mid-operation discards all held words without delivery; counters do not increment on that edge.
REQ-025 No asynchronous reset path; reset_n is not in any sensitivity besides clk.

Configuration
REQ-026 Macro DEMUX_DELIVERY_CNT_EN controls the delivery counters.
REQ-027 With DEMUX_DELIVERY_CNT_EN defined: counter k increments by 1 on each output-k transfer, wraps 255 to 0, port cnt exists.
REQ-028 Without DEMUX_DELIVERY_CNT_EN: no cnt port, no counter flops; all other behaviour identical.

Structure
REQ-029 Package demux_pkg holds SEL_W = 2, N_OUT = 4, CNT_W = 8.
REQ-030 Sub-module demux_out_slot: one-entry holding register with load/valid/ready, parameter n; instantiated four times.
REQ-031 Top contains select decode, in_ready mux, and optional counters; target 120-400 RTL lines.

Verification
REQ-032 Reset, then w=3,5,7,11 with sel=0,1,2,3 on consecutive cycles, out_ready=4'b1111 -> f0=3,f1=5,f2=7,f3=11, each out_valid bit high exactly one cycle, 1-cycle latency.
REQ-033 out_ready=0, w=2 sel=1 accepted, then w=4 sel=1 -> in_ready=0, f1 stays 2; raise out_ready[1] -> 2 delivered, 4 loaded same edge, out_valid[1] stays 1.
REQ-034 Output 1 full and stalled, w=6 sel=2 -> in_ready=1, f2=6 next cycle, f1 unchanged.
REQ-035 Three outputs loaded with 10, 6, 4, reset_n=0 for one edge -> all f=0, out_valid=0, in_ready=1 afterwards.
REQ-036 DEMUX_DELIVERY_CNT_EN defined, 257 deliveries to f3 -> cnt[31:24]=1, other counters 0.
REQ-037 out_ready=4'b1111 with no input for 10 cycles -> outputs hold, out_valid stays 0, counters unchanged.

Source files
------------

// File: rtl/demux_1x4_nbit_stream_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared constants, the output-slot state type and the select decoder for the
// 1-to-4 streaming demultiplexer.
//
// Contents:
//   SEL_W         width of the destination select
//   N_OUT         number of output slots
//   CNT_W         width of each delivery counter (DEMUX_DELIVERY_CNT_EN builds)
//   slot_state_e  occupancy of a one-entry output slot
//   sel_onehot()  select value -> one-hot slot mask
// ----------------------------------------------------------------------------
package demux_pkg;

    localparam int unsigned SEL_W = 2;
    localparam int unsigned N_OUT = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [N_OUT-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        logic [N_OUT-1:0] mask;
        mask    = '0;
        mask[s] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/demux_1x4_nbit_stream_if.sv
// ----------------------------------------------------------------------------
// demux_1x4_nbit_stream_if
// Bundles the input stream and the four output streams of the demultiplexer.
//
// Parameter:
//   n          data width of w and of each output word
// Signals:
//   w          input data word
//   sel        destination select (0..3 -> f0..f3)
//   in_valid   w/sel valid this cycle
//   in_ready   demux accepts w/sel this cycle
//   f0..f3     registered output words
//   out_valid  bit k: fk holds an undelivered word
//   out_ready  bit k: consumer of fk takes the word this cycle
//   cnt        four 8-bit delivery counters (only with DEMUX_DELIVERY_CNT_EN)
// Modports:
//   master     producer/consumer side (testbench or surrounding logic)
//   slave      the demultiplexer itself
// ----------------------------------------------------------------------------
interface demux_1x4_nbit_stream_if #(
    parameter int n = 4
);
    import demux_pkg::*;

    logic [n-1:0]       w;
    logic [SEL_W-1:0]   sel;
    logic               in_valid;
    logic               in_ready;
    logic [n-1:0]       f0;
    logic [n-1:0]       f1;
    logic [n-1:0]       f2;
    logic [n-1:0]       f3;
    logic [N_OUT-1:0]   out_valid;
    logic [N_OUT-1:0]   out_ready;
`ifdef DEMUX_DELIVERY_CNT_EN
    logic [N_OUT*CNT_W-1:0] cnt;
`endif

    modport master (
        output w,
        output sel,
        output in_valid,
        input  in_ready,
        input  f0,
        input  f1,
        input  f2,
        input  f3,
        input  out_valid,
`ifdef DEMUX_DELIVERY_CNT_EN
        input  cnt,
`endif
        output out_ready
    );

    modport slave (
        input  w,
        input  sel,
        input  in_valid,
        output in_ready,
        output f0,
        output f1,
        output f2,
        output f3,
        output out_valid,
`ifdef DEMUX_DELIVERY_CNT_EN
        output cnt,
`endif
        input  out_ready
    );

endinterface

// File: rtl/demux_1x4_nbit_stream_out_slot.sv
// ----------------------------------------------------------------------------
// demux_out_slot
// One-entry holding register for a single demux output. A load always wins
// over a drain, so a word delivered and a new word loaded on the same edge
// leaves the slot full with no bubble. The held word is kept after delivery.
//
// Parameter:
//   n          data width
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   load_i     write data_i into the slot this edge
//   data_i     word to load
//   ready_i    consumer takes the held word this cycle
//   valid_o    slot holds an undelivered word
//   data_o     held word
// ----------------------------------------------------------------------------
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [n-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [n-1:0] data_o
);

    slot_state_e  state_q, state_d;
    logic [n-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_i) begin
            data_d  = data_i;
            state_d = SLOT_FULL;
        end else if (state_q == SLOT_FULL && ready_i) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;

endmodule

// File: rtl/demux_1x4_nbit_stream.sv
// ----------------------------------------------------------------------------
// demux_1x4_nbit_stream
// Streaming 1-to-4 demultiplexer. An accepted word is written into the output
// slot chosen by sel and presented one cycle later. Each output has its own
// one-entry slot, so a stalled output only blocks inputs addressed to it.
//
// Optional feature: define DEMUX_DELIVERY_CNT_EN to add four wrapping 8-bit
// delivery counters on bus.cnt (cnt[8k+7:8k] counts transfers on output k).
//
// Parameter:
//   n          data width
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   bus        demux_1x4_nbit_stream_if.slave (w, sel, in_valid, in_ready,
//              f0..f3, out_valid, out_ready, optional cnt)
// ----------------------------------------------------------------------------
module demux_1x4_nbit_stream
    import demux_pkg::*;
#(
    parameter int n = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    demux_1x4_nbit_stream_if.slave        bus
);

    logic [N_OUT-1:0] valid_w;
    logic [N_OUT-1:0] load_w;
    logic [n-1:0]     f_w [N_OUT];
    logic             in_ready_w;

    // A slot can take a new word when empty or when its word leaves this cycle.
    assign in_ready_w = !valid_w[bus.sel] || bus.out_ready[bus.sel];

    always_comb begin
        load_w = '0;
        if (bus.in_valid && in_ready_w) begin
            load_w = sel_onehot(bus.sel);
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_out_slot #(
            .n (n)
        ) u_slot (
            .clk     (clk),
            .reset_n (reset_n),
            .load_i  (load_w[k]),
            .data_i  (bus.w),
            .ready_i (bus.out_ready[k]),
            .valid_o (valid_w[k]),
            .data_o  (f_w[k])
        );
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = valid_w;
    assign bus.f0        = f_w[0];
    assign bus.f1        = f_w[1];
    assign bus.f2        = f_w[2];
    assign bus.f3        = f_w[3];

`ifdef DEMUX_DELIVERY_CNT_EN
    logic [CNT_W-1:0] cnt_q [N_OUT];
    logic [CNT_W-1:0] cnt_d [N_OUT];

    // Counts completed output handshakes; wraps naturally at 2**CNT_W.
    always_comb begin
        for (int unsigned k = 0; k < N_OUT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (valid_w[k] && bus.out_ready[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (!reset_n) begin
                cnt_q[k] <= '0;
            end else begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
        assign bus.cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_demux_1x4_nbit_stream.sv
// ----------------------------------------------------------------------------
// tb_demux_1x4_nbit_stream
// Self-checking bench for demux_1x4_nbit_stream (n = 4). A per-output
// scoreboard queue receives each accepted word and is popped when the
// corresponding output handshake happens; slot occupancy, held values,
// in_ready and (with DEMUX_DELIVERY_CNT_EN) the counters are compared every
// cycle, alongside directed checks for the documented scenarios.
// ----------------------------------------------------------------------------
module tb_demux_1x4_nbit_stream;

    logic clk;
    logic reset_n;

    demux_1x4_nbit_stream_if #(.n(4)) bus ();

    demux_1x4_nbit_stream #(
        .n (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [3:0] sbq    [4][$];
    logic [3:0] last_f [4];
    logic [7:0] exp_cnt[4];
    logic [3:0] fv     [4];

    assign fv[0] = bus.f0;
    assign fv[1] = bus.f1;
    assign fv[2] = bus.f2;
    assign fv[3] = bus.f3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            sbq[k].delete();
            last_f[k]  = '0;
            exp_cnt[k] = '0;
        end
    endtask

    // Called at a falling edge with inputs already driven; checks the state
    // left by the previous edge, advances the model, then runs one cycle.
    task automatic step();
        logic       exp_rdy;
        logic [3:0] exp_w;
        #1;
        exp_rdy = (sbq[bus.sel].size() == 0) || bus.out_ready[bus.sel];
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        for (int k = 0; k < 4; k++) begin
            chk("out_valid", {31'd0, bus.out_valid[k]}, {31'd0, sbq[k].size() != 0});
            chk("f_hold", {28'd0, fv[k]}, {28'd0, last_f[k]});
        end
`ifdef DEMUX_DELIVERY_CNT_EN
        chk("cnt", bus.cnt, {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]});
`endif
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) begin
                sbq[k].delete();
                last_f[k]  = '0;
                exp_cnt[k] = '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (sbq[k].size() != 0 && bus.out_ready[k]) begin
                    exp_w = sbq[k].pop_front();
                    chk("sb_deliver", {28'd0, fv[k]}, {28'd0, exp_w});
                    exp_cnt[k] = exp_cnt[k] + 8'd1;
                end
            end
            if (bus.in_valid && exp_rdy) begin
                sbq[bus.sel].push_back(bus.w);
                last_f[bus.sel] = bus.w;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] ws [4];
        ws = '{4'd3, 4'd5, 4'd7, 4'd11};

        bus.w         = '0;
        bus.sel       = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = '0;
        reset_n       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_clear();

        // Reset state
        step();
        step();
        chk("rst_ov", {28'd0, bus.out_valid}, 32'd0);
        chk("rst_f0", {28'd0, bus.f0}, 32'd0);
        chk("rst_f3", {28'd0, bus.f3}, 32'd0);
        reset_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            bus.sel = 2'(s);
            #1;
            chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        end

        // Back-to-back words to each output, all consumers ready
        bus.out_ready = 4'hF;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.w   = ws[i];
            bus.sel = 2'(i);
            step();
            chk("seq_ov", {28'd0, bus.out_valid}, 32'd1 << i);
            chk("seq_f", {28'd0, fv[i]}, {28'd0, ws[i]});
        end
        bus.in_valid = 1'b0;
        step();
        chk("seq_drain", {28'd0, bus.out_valid}, 32'd0);

        // Stall on output 1, then deliver-and-reload on the same edge
        bus.out_ready = 4'h0;
        bus.in_valid  = 1'b1;
        bus.w         = 4'd2;
        bus.sel       = 2'd1;
        step();
        bus.w = 4'd4;
        #1;
        chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        chk("stall_f1", {28'd0, bus.f1}, 32'd2);
        bus.out_ready = 4'b0010;
        #1;
        chk("reload_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        chk("reload_ov1", {31'd0, bus.out_valid[1]}, 32'd1);
        chk("reload_f1", {28'd0, bus.f1}, 32'd4);

        // Other outputs stay open while output 1 is stalled
        bus.out_ready = 4'h0;
        bus.w         = 4'd6;
        bus.sel       = 2'd2;
        #1;
        chk("indep_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        chk("indep_f2", {28'd0, bus.f2}, 32'd6);
        chk("indep_f1", {28'd0, bus.f1}, 32'd4);
        bus.w   = 4'd10;
        bus.sel = 2'd0;
        step();
        chk("three_full", {28'd0, bus.out_valid}, 32'h7);

        // Reset mid-operation discards held words
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'hF;
        reset_n       = 1'b0;
        step();
        reset_n = 1'b1;
        chk("midrst_ov", {28'd0, bus.out_valid}, 32'd0);
        chk("midrst_f0", {28'd0, bus.f0}, 32'd0);
        chk("midrst_f1", {28'd0, bus.f1}, 32'd0);
        chk("midrst_f2", {28'd0, bus.f2}, 32'd0);
        for (int s = 0; s < 4; s++) begin
            bus.sel = 2'(s);
            #1;
            chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        end

        // Idle with consumers ready: outputs hold, w/sel ignored
        bus.in_valid = 1'b1;
        bus.w        = 4'd9;
        bus.sel      = 2'd2;
        step();
        bus.w   = 4'd13;
        bus.sel = 2'd3;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.w   = 4'($urandom);
            bus.sel = 2'($urandom);
            step();
        end
        chk("idle_ov", {28'd0, bus.out_valid}, 32'd0);
        chk("idle_f2", {28'd0, bus.f2}, 32'd9);
        chk("idle_f3", {28'd0, bus.f3}, 32'd13);

        // Random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.w         = 4'($urandom);
            bus.sel       = 2'($urandom);
            bus.out_ready = 4'($urandom);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'hF;
        step();
        chk("rand_drain", {28'd0, bus.out_valid}, 32'd0);

`ifdef DEMUX_DELIVERY_CNT_EN
        // 257 deliveries to f3 wrap its counter to 1
        reset_n = 1'b0;
        step();
        reset_n       = 1'b1;
        bus.out_ready = 4'hF;
        bus.in_valid  = 1'b1;
        bus.sel       = 2'd3;
        for (int i = 0; i < 257; i++) begin
            bus.w = 4'(i);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        chk("cnt_wrap", bus.cnt, 32'h0100_0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
